sc_frame_loader: RTL and testbench

//  Upstream stage of the MAROC slow-control transmitter. Accepts the 829-bit SC frame as a

---
 rtl/sc_frame_loader.sv | 166 ++++++++++++++++
 tb/tb_sc_frame_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_frame_loader.sv
// Byte-stream loader for the 829-bit MAROC slow-control frame: assembles into a shadow
// register, validates length/timeout (and CRC-8 when SC_CRC_EN is defined), then commits atomically.
module sc_frame_loader #(
  parameter int unsigned FRAME_BITS  = 829,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  CK_SC,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  tx_busy,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  set_new_data,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [15:0]           frame_cnt
);
  localparam int unsigned NBYTES = (FRAME_BITS + 7) / 8;
`ifdef SC_CRC_EN
  localparam int unsigned NEXP   = NBYTES + 1;
`else
  localparam int unsigned NEXP   = NBYTES;
`endif
  localparam int unsigned CNT_W  = $clog2(NEXP + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LAST_W = FRAME_BITS - 8 * (NBYTES - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, CHECK, WAIT_TX, COMMIT} state_t;
  typedef enum logic [1:0] {ERR_SHORT = 2'b00, ERR_LONG = 2'b01,
                            ERR_TIMEOUT = 2'b10, ERR_CRC = 2'b11} err_t;

  state_t                state, state_nx;
  err_t                  err_sel;
  logic                  err_fire;
  logic                  xfer, cnt_last, wr_data, crc_ok;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic [TMR_W-1:0]      timer;
  logic [FRAME_BITS-1:0] shadow;

  assign xfer     = s_valid & s_ready;
  assign cnt_inc  = cnt + 1'b1;
  assign cnt_last = (cnt_inc == CNT_W'(NEXP));
  assign wr_data  = xfer && ((state == IDLE) || (state == COLLECT)) && (cnt < CNT_W'(NBYTES));

  always_comb begin
    state_nx = state;
    err_fire = 1'b0;
    err_sel  = ERR_SHORT;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (s_last) err_fire = 1'b1;
          else        state_nx = COLLECT;
        end
      end
      COLLECT: begin
        // A transfer in the timeout cycle takes priority over the timeout.
        if (xfer) begin
          if (s_last && cnt_last) begin
            state_nx = CHECK;
          end else if (s_last) begin
            err_fire = 1'b1;
            state_nx = IDLE;
          end else if (cnt_last) begin
            err_fire = 1'b1;
            err_sel  = ERR_LONG;
            state_nx = DRAIN;
          end
        end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          err_fire = 1'b1;
          err_sel  = ERR_TIMEOUT;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (xfer && s_last) state_nx = IDLE;
      end
      CHECK: begin
        if (!crc_ok) begin
          err_fire = 1'b1;
          err_sel  = ERR_CRC;
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (!tx_busy) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so COMMIT-entry is the commit edge.
  always_ff @(posedge CK_SC or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      timer        <= '0;
      shadow       <= '0;
      s_ready      <= 1'b1;
      frame_out    <= '0;
      set_new_data <= 1'b0;
      err_pulse    <= 1'b0;
      err_code     <= '0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nx;
      s_ready      <= (state_nx == IDLE) || (state_nx == COLLECT) || (state_nx == DRAIN);
      set_new_data <= (state_nx == COMMIT);
      err_pulse    <= err_fire;
      if (err_fire) err_code <= err_sel;

      if (state_nx != COLLECT) cnt <= '0;
      else if (xfer)           cnt <= cnt_inc;

      if ((state == COLLECT) && (state_nx == COLLECT) && !xfer) timer <= timer + 1'b1;
      else                                                      timer <= '0;

      for (int unsigned i = 0; i < NBYTES - 1; i++) begin
        if (wr_data && (cnt == CNT_W'(i))) shadow[8*i +: 8] <= s_data;
      end
      if (wr_data && (cnt == CNT_W'(NBYTES - 1)))
        shadow[FRAME_BITS-1 -: LAST_W] <= s_data[LAST_W-1:0];

      if (state_nx == COMMIT) begin
        frame_out <= shadow;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

`ifdef SC_CRC_EN
  logic [7:0] crc, crc_rx;
  logic       wr_crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned b = 0; b < 8; b++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  assign wr_crc = xfer && (state == COLLECT) && (cnt == CNT_W'(NBYTES));

  always_ff @(posedge CK_SC or negedge rst_n) begin
    if (!rst_n) begin
      crc    <= '0;
      crc_rx <= '0;
    end else if (wr_data) begin
      crc <= crc8_step((state == IDLE) ? 8'h00 : crc, s_data);
    end else if (wr_crc) begin
      crc_rx <= s_data;
    end
  end

  assign crc_ok = (crc == crc_rx);
`else
  assign crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_sc_frame_loader.sv
// Directed self-checking bench for sc_frame_loader (TIMEOUT_CYC shortened to 16).
module tb_sc_frame_loader;
  localparam int FRAME_BITS = 829;
  localparam int NBYTES     = 104;
`ifdef SC_CRC_EN
  localparam int NEXP = NBYTES + 1;
`else
  localparam int NEXP = NBYTES;
`endif

  logic                  CK_SC = 1'b0;
  logic                  rst_n = 1'b0;
  logic [7:0]            s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_last = 1'b0;
  logic                  s_ready;
  logic                  tx_busy = 1'b0;
  logic [FRAME_BITS-1:0] frame_out;
  logic                  set_new_data;
  logic                  err_pulse;
  logic [1:0]            err_code;
  logic [15:0]           frame_cnt;

  int checks = 0, errors = 0;
  int snd_seen = 0, err_seen = 0, both_seen = 0;
  int sent = 0, err_at = -1, stalls = 0;
  logic [1:0] last_code = '0;

  always #5 CK_SC = ~CK_SC;

  sc_frame_loader #(.FRAME_BITS(FRAME_BITS), .TIMEOUT_CYC(16)) dut (
    .CK_SC(CK_SC), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tx_busy(tx_busy), .frame_out(frame_out), .set_new_data(set_new_data),
    .err_pulse(err_pulse), .err_code(err_code), .frame_cnt(frame_cnt)
  );

  always @(negedge CK_SC) begin
    if (set_new_data) snd_seen++;
    if (err_pulse) begin
      err_seen++;
      last_code = err_code;
      err_at    = sent;
    end
    if (set_new_data && err_pulse) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic logic [FRAME_BITS-1:0] exp_frame(input int off);
    logic [8*NBYTES-1:0] t;
    t = '0;
    for (int k = 0; k < NBYTES; k++) t[8*k +: 8] = 8'(k + off);
    return t[FRAME_BITS-1:0];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    @(negedge CK_SC);
    s_data = d; s_valid = 1'b1; s_last = last;
    w = 0;
    if (!s_ready) stalls++;
    while (!s_ready && w < 50) begin
      @(negedge CK_SC);
      w++;
    end
    if (w >= 50) check("ready_wait_expired", 32'd0, 32'd1);
    @(posedge CK_SC);
    sent++;
  endtask

  // Data bytes are (k+off); byte NBYTES is the CRC (xor'd with crc_xor); later bytes are filler.
  task automatic send_frame(input int nbytes, input int last_idx, input int off, input logic [7:0] crc_xor);
    logic [7:0] crc, b;
    crc  = 8'h00;
    sent = 0;
    for (int k = 0; k < nbytes; k++) begin
      if (k < NBYTES) begin
        b   = 8'(k + off);
        crc = crc8(crc, b);
      end else if (k == NBYTES) begin
        b = crc ^ crc_xor;
      end else begin
        b = 8'(k);
      end
      send_byte(b, k == last_idx);
    end
    @(negedge CK_SC);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_BITS-1:0] held;
    int c, snd0;
    logic ok;

    repeat (3) @(negedge CK_SC);
    check("rst_s_ready",     32'(s_ready), 32'd1);
    check("rst_frame_zero",  32'(frame_out == '0), 32'd1);
    check("rst_snd",         32'(set_new_data), 32'd0);
    check("rst_err_pulse",   32'(err_pulse), 32'd0);
    check("rst_err_code",    32'(err_code), 32'd0);
    check("rst_frame_cnt",   32'(frame_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: good frame, latency
    send_frame(NEXP, NEXP - 1, 0, 8'h00);
    check("s1_ready_low_check", 32'(s_ready), 32'd0);
    check("s1_snd_n05", 32'(set_new_data), 32'd0);
    @(negedge CK_SC);
    check("s1_snd_n15", 32'(set_new_data), 32'd0);
    @(negedge CK_SC);
    check("s1_snd_n25", 32'(set_new_data), 32'd1);
    check("s1_byte0",   32'(frame_out[7:0]), 32'h00);
    check("s1_byte1",   32'(frame_out[15:8]), 32'h01);
    check("s1_top5",    32'(frame_out[828:824]), 32'h07);
    check("s1_frame",   32'(frame_out == exp_frame(0)), 32'd1);
    check("s1_cnt",     32'(frame_cnt), 32'd1);
    @(negedge CK_SC);
    check("s1_snd_once", 32'(set_new_data), 32'd0);
    repeat (2) @(negedge CK_SC);
    check("s1_snd_total", 32'(snd_seen), 32'd1);
    check("s1_no_err",    32'(err_seen), 32'd0);

    // 2: short frame
    held = frame_out;
    send_frame(51, 50, 5, 8'h00);
    repeat (3) @(negedge CK_SC);
    check("s2_err_count", 32'(err_seen), 32'd1);
    check("s2_err_code",  32'(last_code), 32'd0);
    check("s2_frame_kept", 32'(frame_out == held), 32'd1);
    check("s2_no_snd",    32'(snd_seen), 32'd1);

    // 3: long frame, then a good frame
    stalls = 0;
    send_frame(110, 109, 0, 8'h00);
    repeat (2) @(negedge CK_SC);
    check("s3_err_count", 32'(err_seen), 32'd2);
    check("s3_err_code",  32'(last_code), 32'd1);
    check("s3_err_at",    32'(err_at), 32'(NEXP));
    check("s3_no_stall",  32'(stalls), 32'd0);
    check("s3_ready_idle", 32'(s_ready), 32'd1);
    send_frame(NEXP, NEXP - 1, 3, 8'h00);
    repeat (4) @(negedge CK_SC);
    check("s3_good_cnt",   32'(frame_cnt), 32'd2);
    check("s3_good_frame", 32'(frame_out == exp_frame(3)), 32'd1);
    check("s3_err_same",   32'(err_seen), 32'd2);

    // 4: timeout after 10 bytes
    send_frame(10, -1, 0, 8'h00);
    c = 0; ok = 1'b0;
    while (!ok && c < 40) begin
      @(posedge CK_SC); #1;
      c++;
      ok = err_pulse;
    end
    check("s4_timeout_cycles", 32'(c), 32'd16);
    check("s4_err_code", 32'(err_code), 32'd2);
    send_frame(NEXP, NEXP - 1, 7, 8'h00);
    repeat (4) @(negedge CK_SC);
    check("s4_err_count", 32'(err_seen), 32'd3);
    check("s4_next_cnt",  32'(frame_cnt), 32'd3);
    check("s4_next_frame", 32'(frame_out == exp_frame(7)), 32'd1);

    // 5: backpressure from the transmitter
    tx_busy = 1'b1;
    send_frame(NEXP, NEXP - 1, 9, 8'h00);
    ok = 1'b1;
    repeat (20) begin
      @(negedge CK_SC);
      if (s_ready || set_new_data) ok = 1'b0;
    end
    check("s5_held_off", 32'(ok), 32'd1);
    check("s5_cnt_held", 32'(frame_cnt), 32'd3);
    snd0 = snd_seen;
    tx_busy = 1'b0;
    @(negedge CK_SC);
    check("s5_snd_high", 32'(set_new_data), 32'd1);
    check("s5_frame",    32'(frame_out == exp_frame(9)), 32'd1);
    @(negedge CK_SC);
    check("s5_snd_low",  32'(set_new_data), 32'd0);
    repeat (2) @(negedge CK_SC);
    check("s5_snd_once", 32'(snd_seen - snd0), 32'd1);
    check("s5_cnt",      32'(frame_cnt), 32'd4);

    // 6: reset mid-frame
    send_frame(61, -1, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("s6_frame_zero", 32'(frame_out == '0), 32'd1);
    check("s6_ready",      32'(s_ready), 32'd1);
    check("s6_cnt",        32'(frame_cnt), 32'd0);
    check("s6_err_code",   32'(err_code), 32'd0);
    check("s6_pulses",     32'({set_new_data, err_pulse}), 32'd0);
    @(negedge CK_SC);
    rst_n = 1'b1;
    send_frame(NEXP, NEXP - 1, 11, 8'h00);
    repeat (4) @(negedge CK_SC);
    check("s6_after_cnt",   32'(frame_cnt), 32'd1);
    check("s6_after_frame", 32'(frame_out == exp_frame(11)), 32'd1);

`ifdef SC_CRC_EN
    // 7: CRC good then corrupted
    send_frame(NEXP, NEXP - 1, 0, 8'h00);
    repeat (4) @(negedge CK_SC);
    check("s7_crc_ok_cnt",   32'(frame_cnt), 32'd2);
    check("s7_crc_ok_frame", 32'(frame_out == exp_frame(0)), 32'd1);
    c = err_seen;
    send_frame(NEXP, NEXP - 1, 13, 8'h01);
    repeat (4) @(negedge CK_SC);
    check("s7_crc_err_count", 32'(err_seen - c), 32'd1);
    check("s7_crc_err_code",  32'(last_code), 32'd3);
    check("s7_crc_no_commit", 32'(frame_cnt), 32'd2);
    check("s7_crc_frame_kept", 32'(frame_out == exp_frame(0)), 32'd1);
`endif

    check("never_both_pulses", 32'(both_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
